freq_gen: RTL and testbench
===========================

Name: freq_gen

Overview:
Stimulus-side counterpart of the toggle-rate frequency counter: takes a decimal digit 0-9 and produces a 1-bit signal whose toggle density falls in the centre of that digit's counter bin. Sits in front of the counter's sig input for loopback self-test, or drives an external pin as a programmable low-rate tone source. Uses a first-order phase accumulator so toggles are evenly spaced, with no bursts. A settle counter reports when a downstream DEPTH-window averager has fully seen the new rate.

Parameters:
DEPTH, 250, settle window in clk cycles; matches the counter's averaging depth.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable_i  in  1  1 = generate toggles; 0 = hold sig_o
load_i  in  1  single-cycle strobe; latches the digit input
digit_i  in  4  binary digit; values >9 clamp to 9
sig_o  out  1  generated signal
digit_o  out  4  digit currently in effect
settled_o  out  1  1 = DEPTH consecutive RUN cycles since the last load or enable rise
bad_code_o  out  1  1 = last loaded code was out of range or undecodable (sticky until next load)

Behaviour:
- Reset, when reset=1 at a posedge (has priority over everything):
  - sig_o=0, digit_o=0, acc=0, settle_cnt=0, settled_o=0, bad_code_o=0
  - state=IDLE
- Constants:
  - MOD=20
  - step = 2*digit+1, so target toggles/cycle = (2d+1)/20 (0.05 … 0.95)
  - acc is 5 bits, range 0..19
- States:
  - IDLE to RUN when enable_i=1.
  - RUN to IDLE when enable_i=0.
  - Transitions take effect at the same posedge where enable_i is sampled.
- In RUN, each posedge:
  - sum = acc + step (6 bits).
  - If sum >= 20: acc <= sum-20 and sig_o <= ~sig_o.
  - Otherwise: acc <= sum, sig_o unchanged.
- In IDLE:
  - sig_o and acc hold.
  - settle_cnt <= 0, settled_o <= 0.
- Load:
  - load_i=1 at a posedge latches the clamped digit into digit_o.
  - New step is used from the next posedge; latency is 1 cycle.
  - acc is NOT cleared, so no phase glitch occurs.
  - settle_cnt <= 0, settled_o <= 0.
  - bad_code_o <= (digit_i>9).
  - Load is accepted in both IDLE and RUN.
  - Load and enable change in the same cycle: both take effect.
- Settle counter:
  - Width $clog2(DEPTH+1). Increments once per RUN cycle and saturates at DEPTH.
  - settled_o=1 when settle_cnt==DEPTH, registered.
  - A load in the same cycle as saturation wins: the counter clears.
- Steady state: any 20 consecutive RUN cycles contain exactly 2d+1 toggles, because the acc sequence is periodic with period 20.
- Reset mid-RUN: all state returns to reset values on the next posedge. Generation resumes only when enable_i is seen high again.

Optional Feature:
- Macro name: FREQ_GEN_SEG_IN_EN.
- When defined:
  - Adds input seg_i [6:0], active-high segments a..g in the counter's seg7 encoding.
  - On load, seg_i is decoded to a digit and digit_i is ignored.
  - An undecodable pattern leaves digit_o unchanged and sets bad_code_o=1.
- When undefined:
  - No seg_i port; digit_i is used.
- All other behaviour is identical.

Decomposition:
- Package freq_gen_pkg holds:
  - MOD=20
  - DIGIT_MAX=9
  - step width / acc width constants
  - the 10 seven-segment code constants, shared with the seg7 encoder
  - state enum {IDLE, RUN}
- One sub-module, seg7_decode: combinational seg_i -> {valid, digit[3:0]}. Instantiated only under FREQ_GEN_SEG_IN_EN.

Test Plan:
- Reset, enable=1, load digit 0, run 200 cycles -> exactly 10 toggles, spaced every 20 cycles. digit_o=0.
- Load digit 9, run 20 cycles after one cycle of latency -> 19 toggles. Over 250 cycles, 237 or 238 toggles.
- Load digit 12 -> digit_o=9, bad_code_o=1, density 19/20. A following load of 4 -> bad_code_o=0, 9 toggles per 20 cycles.
- Settling:
  - Load 5, count: settled_o rises exactly DEPTH=250 RUN cycles after load.
  - A reload at cycle 100 -> settled_o stays 0 until 250 cycles after the reload.
  - Dropping enable for 1 cycle clears settle_cnt and holds sig_o.
- Assert reset mid-RUN with sig_o=1, digit 7 -> next cycle sig_o=0, digit_o=0, settled_o=0, no toggles until enable is seen.
- Loopback into the frequency counter (DEPTH=250): each digit 0-9 loaded, wait for settled_o + 2 cycles -> counter digit equals the loaded digit. With FREQ_GEN_SEG_IN_EN, the seg code for 3 gives counter 3, and segment code 7'h00 gives bad_code_o=1.

Source files
------------

// File: rtl/freq_gen_pkg.sv
// -----------------------------------------------------------------------------
// freq_gen_pkg
// Shared constants and types for the programmable toggle-rate generator.
//   - Phase accumulator modulus and widths
//   - Digit range limit and clamp helper
//   - Seven-segment codes (active-high, bit 0 = segment a ... bit 6 = segment g),
//     identical to the ones used by the counter's seg7 encoder
//   - Generator state type
// -----------------------------------------------------------------------------
package freq_gen_pkg;

  localparam int MOD       = 20;
  localparam int DIGIT_MAX = 9;
  localparam int DIGIT_W   = 4;
  localparam int STEP_W    = 5;  // 2*9+1 = 19 fits in 5 bits
  localparam int ACC_W     = 5;  // accumulator range 0..19
  localparam int SUM_W     = 6;  // acc + step <= 19 + 19 = 38

  localparam logic [SUM_W-1:0] MOD_SUM = SUM_W'(MOD);

  // Seven-segment codes, {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Out-of-range binary digits saturate at the top bin.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_W'(DIGIT_MAX)) ? DIGIT_W'(DIGIT_MAX) : d;
  endfunction

endpackage

// File: rtl/freq_gen_seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational seven-segment to binary digit decoder. Only the ten exact
// codes of the shared encoder are accepted; anything else reports valid=0.
// Ports:
//   seg   in  7  active-high segments {g,f,e,d,c,b,a}
//   valid out 1  1 = seg matched one of the ten digit codes
//   digit out 4  decoded digit (0 when not valid)
// -----------------------------------------------------------------------------
module seg7_decode
  import freq_gen_pkg::*;
(
  input  logic [6:0]         seg,
  output logic               valid,
  output logic [DIGIT_W-1:0] digit
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    valid = 1'b1;
    digit = '0;
    case (seg)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/freq_gen.sv
// -----------------------------------------------------------------------------
// freq_gen
// Programmable low-rate toggle source. A first-order phase accumulator adds
// step = 2*digit+1 each running cycle modulo 20 and toggles sig_o on every
// wrap, giving (2d+1)/20 toggles per cycle with evenly spaced edges. A settle
// counter flags when a downstream DEPTH-cycle averager has seen only the
// current rate.
//
// Build option: define FREQ_GEN_SEG_IN_EN to load the digit from a
// seven-segment pattern on seg_i instead of digit_i.
//
// Ports:
//   clk         in  1  clock
//   reset       in  1  synchronous, active-high reset
//   enable_i    in  1  1 = generate toggles, 0 = hold sig_o
//   load_i      in  1  single-cycle strobe, latches the new digit
//   digit_i     in  4  binary digit, values above 9 clamp to 9
//   seg_i       in  7  (FREQ_GEN_SEG_IN_EN only) segment pattern to load
//   sig_o       out 1  generated signal
//   digit_o     out 4  digit currently in effect
//   settled_o   out 1  DEPTH consecutive running cycles since last load/enable rise
//   bad_code_o  out 1  last loaded code was out of range or undecodable
// -----------------------------------------------------------------------------
module freq_gen
  import freq_gen_pkg::*;
#(
  parameter int DEPTH = 250
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable_i,
  input  logic               load_i,
  input  logic [DIGIT_W-1:0] digit_i,
`ifdef FREQ_GEN_SEG_IN_EN
  input  logic [6:0]         seg_i,
`endif
  output logic               sig_o,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               settled_o,
  output logic               bad_code_o
);

  localparam int                CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_e             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   settle_cnt;

  // ---------------------------------------------------------------------------
  // Load source selection: what a load strobe would write this cycle.
  // ---------------------------------------------------------------------------
  logic               load_ok;     // digit_o may be overwritten
  logic [DIGIT_W-1:0] load_digit;
  logic               load_bad;

`ifdef FREQ_GEN_SEG_IN_EN
  logic               seg_valid;
  logic [DIGIT_W-1:0] seg_digit;
  logic               unused_digit_in;

  seg7_decode u_seg7_decode (
    .seg   (seg_i),
    .valid (seg_valid),
    .digit (seg_digit)
  );

  // An undecodable pattern keeps the previous digit and only raises the flag.
  assign load_ok         = seg_valid;
  assign load_digit      = seg_digit;
  assign load_bad        = ~seg_valid;
  assign unused_digit_in = ^digit_i;
`else
  assign load_ok    = 1'b1;
  assign load_digit = clamp_digit(digit_i);
  assign load_bad   = (digit_i > DIGIT_W'(DIGIT_MAX));
`endif

  // ---------------------------------------------------------------------------
  // Phase accumulator datapath.
  // ---------------------------------------------------------------------------
  logic [STEP_W-1:0] step;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_wrapped;
  logic              wrap;
  logic [ACC_W-1:0]  acc_next;

  assign step        = {digit_o, 1'b1};                 // 2*digit + 1
  assign sum         = SUM_W'(acc) + SUM_W'(step);
  assign wrap        = (sum >= MOD_SUM);
  assign sum_wrapped = sum - MOD_SUM;
  // sum < 40, so either branch already lies in 0..19 and fits ACC_W bits.
  assign acc_next    = wrap ? sum_wrapped[ACC_W-1:0] : sum[ACC_W-1:0];

  // ---------------------------------------------------------------------------
  // Settle counter next value for a running cycle. The first running cycle
  // after IDLE restarts the window at 1; afterwards it saturates at DEPTH.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = settle_cnt;
    if (state == IDLE) begin
      cnt_next = CNT_W'(1);
    end else if (settle_cnt != DEPTH_C) begin
      cnt_next = settle_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State. The state follows enable_i at the same edge where it is sampled,
  // so a cycle with enable_i=1 is already a running cycle.
  // ---------------------------------------------------------------------------
  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  // NOTE: reset is synchronous; only control and datapath flops exist here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      sig_o      <= 1'b0;
      digit_o    <= '0;
      settle_cnt <= '0;
      settled_o  <= 1'b0;
      bad_code_o <= 1'b0;
    end else begin
      state <= enable_i ? RUN : IDLE;

      // The step in use here is the pre-load digit; acc is never cleared on
      // a load, so a rate change introduces no phase discontinuity.
      if (enable_i) begin
        acc <= acc_next;
        if (wrap) begin
          sig_o <= ~sig_o;
        end
      end

      if (load_i) begin
        settle_cnt <= '0;
        settled_o  <= 1'b0;
        bad_code_o <= load_bad;
        if (load_ok) begin
          digit_o <= load_digit;
        end
      end else if (enable_i) begin
        settle_cnt <= cnt_next;
        settled_o  <= (cnt_next == DEPTH_C);
      end else begin
        settle_cnt <= '0;
        settled_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_freq_gen.sv
// -----------------------------------------------------------------------------
// tb_freq_gen
// Self-checking bench for freq_gen. A reference model tracks the generator as
// an unwrapped phase (sig = which half of a 40-unit period the phase is in),
// a run-length count and the loaded digit; a compare process checks every
// output against it each cycle, and directed sequences pin toggle counts,
// toggle spacing and settle latency with hand-computed numbers.
// -----------------------------------------------------------------------------
module tb_freq_gen;

  localparam int DEPTH = 250;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       load;
  logic [3:0] digit;
  logic [6:0] seg;
  logic       sig_o;
  logic [3:0] digit_o;
  logic       settled_o;
  logic       bad_code_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  freq_gen #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable_i   (enable),
    .load_i     (load),
    .digit_i    (digit),
`ifdef FREQ_GEN_SEG_IN_EN
    .seg_i      (seg),
`endif
    .sig_o      (sig_o),
    .digit_o    (digit_o),
    .settled_o  (settled_o),
    .bad_code_o (bad_code_o)
  );

  task automatic check(input string name, input integer act, input integer exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int m_phase;    // total phase modulo 40; sig is high in the upper half
  int m_digit;
  int m_bad;
  int m_run;      // running cycles since last load / enable rise
  bit m_valid = 1'b0;

  function automatic int seg_to_digit(input logic [6:0] s);
    logic [6:0] codes [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    for (int i = 0; i < 10; i++) if (codes[i] == s) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= 0;
      m_digit <= 0;
      m_bad   <= 0;
      m_run   <= 0;
      m_valid <= 1'b1;
    end else begin
      if (enable) m_phase <= (m_phase + 2 * m_digit + 1) % 40;
      m_run <= load ? 0 : (enable ? m_run + 1 : 0);
      if (load) begin
`ifdef FREQ_GEN_SEG_IN_EN
        if (seg_to_digit(seg) >= 0) m_digit <= seg_to_digit(seg);
        m_bad <= (seg_to_digit(seg) < 0) ? 1 : 0;
`else
        m_digit <= (digit > 9) ? 9 : int'(digit);
        m_bad   <= (digit > 9) ? 1 : 0;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_sig",     sig_o,      (m_phase >= 20) ? 1 : 0);
      check("cyc_digit",   digit_o,    m_digit);
      check("cyc_settled", settled_o,  (m_run >= DEPTH) ? 1 : 0);
      check("cyc_bad",     bad_code_o, m_bad);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called and returning at a negedge)
  // ---------------------------------------------------------------------------
  task automatic load_digit(input int d);
    @(negedge clk);
    load  = 1'b1;
    digit = 4'(d);
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Counts toggles over n cycles; first/last are the cycle indices (1-based)
  // of the first and last observed toggle.
  task automatic count_toggles(input int n, output int cnt, output int first, output int last);
    logic prev;
    prev  = sig_o;
    cnt   = 0;
    first = 0;
    last  = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (sig_o !== prev) begin
        cnt++;
        if (first == 0) first = i;
        last = i;
      end
      prev = sig_o;
    end
  endtask

  // Cycles until settled_o is seen high, bounded.
  task automatic wait_settled(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!settled_o && k < 400);
  endtask

  int c, f, l, k;
  logic s;

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    load   = 1'b0;
    digit  = 4'd0;
    seg    = 7'h3F;
    repeat (2) @(negedge clk);
    check("reset_sig",     sig_o,      0);
    check("reset_digit",   digit_o,    0);
    check("reset_settled", settled_o,  0);
    check("reset_bad",     bad_code_o, 0);
    reset = 1'b0;

    // Digit 0: one toggle every 20 cycles.
    load_digit(0);
    enable = 1'b1;
    count_toggles(200, c, f, l);
    check("d0_toggles", c, 10);
    check("d0_first",   f, 20);
    check("d0_last",    l, 200);
    check("d0_digit",   digit_o, 0);

    // Digit 9: 19 per 20, 237..238 per 250.
    load_digit(9);
    count_toggles(20, c, f, l);
    check("d9_toggles20", c, 19);
    count_toggles(250, c, f, l);
    check("d9_toggles250_range", (c == 237 || c == 238) ? 1 : 0, 1);

    // Out-of-range code clamps and flags; the next good load clears the flag.
    load_digit(12);
    check("d12_digit", digit_o, 9);
    check("d12_bad",   bad_code_o, 1);
    count_toggles(20, c, f, l);
    check("d12_toggles20", c, 19);
    load_digit(4);
    check("d4_bad",   bad_code_o, 0);
    check("d4_digit", digit_o, 4);
    count_toggles(20, c, f, l);
    check("d4_toggles20", c, 9);

    // Settling after a load, after a reload, and after an enable drop.
    load_digit(5);
    wait_settled(k);
    check("settle_after_load", k, 250);
    load_digit(5);
    repeat (98) @(negedge clk);
    check("settle_before_reload", settled_o, 0);
    load_digit(5);
    wait_settled(k);
    check("settle_after_reload", k, 250);
    @(negedge clk);
    enable = 1'b0;
    s = sig_o;
    @(negedge clk);
    check("drop_settled", settled_o, 0);
    check("drop_sig_hold", sig_o, s);
    enable = 1'b1;
    wait_settled(k);
    check("settle_after_enable", k, 250);

    // Reset in the middle of a run with sig_o high.
    load_digit(7);
    k = 0;
    while (sig_o !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("mid_sig_high_seen", sig_o, 1);
    reset  = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("mid_reset_sig",     sig_o, 0);
    check("mid_reset_digit",   digit_o, 0);
    check("mid_reset_settled", settled_o, 0);
    count_toggles(30, c, f, l);
    check("mid_reset_idle_toggles", c, 0);
    enable = 1'b1;
    count_toggles(20, c, f, l);
    check("mid_reset_resume", c, 1);

    // Sweep all digits: settle, then 2d+1 toggles per 20 cycles.
    for (int d = 0; d < 10; d++) begin
      load_digit(d);
      wait_settled(k);
      check($sformatf("sweep%0d_settle", d), k, 250);
      count_toggles(20, c, f, l);
      check($sformatf("sweep%0d_toggles", d), c, 2 * d + 1);
    end

`ifdef FREQ_GEN_SEG_IN_EN
    seg = 7'h4F;
    load_digit(0);
    check("seg3_digit", digit_o, 3);
    check("seg3_bad",   bad_code_o, 0);
    seg = 7'h00;
    load_digit(0);
    check("seg00_digit", digit_o, 3);
    check("seg00_bad",   bad_code_o, 1);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
